seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-anode/common-cathode 7-segment digits, successor to the single-digit hex-to-segment encoder. Latches a packed multi-digit hex value, scans one digit at a time at a programmable rate, and provides per-digit decimal points, blanking, leading-zero suppression, and frame-synchronous double buffering so the display never tears. Sits between the CPU's display/IO register and the board's segment and digit pins.

---
 rtl/seg7_scan_driver.sv | 206 ++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a bank of 7-segment digits. A packed hex value
// (with per-digit dp and blank flags) is captured into a shadow buffer on
// `load` and copied into the active buffer only at the end of a full scan,
// so a frame is never drawn from a mix of old and new data. One digit is
// lit per slot of SCAN_DIV cycles. The first cycle of every slot has all
// digit enables off to hide segment transitions.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   data_in      packed hex digits, digit k at [4k+3:4k], digit 0 is LSD
//   dp_in        per-digit decimal point request (captured on load)
//   blank_in     per-digit blank, forces segments and dp off (captured on load)
//   load         one-cycle strobe capturing data_in/dp_in/blank_in
//   lz_en        leading-zero suppression enable, used live
//   seg_out      segments {g,f,e,d,c,b,a}, pin polarity
//   dp_out       decimal point of the lit digit, pin polarity
//   dig_sel      one-hot digit enable, pin polarity
//   frame_tick   one-cycle pulse in the cycle after each scan wrap
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  localparam logic [6:0]        SEG_OFF = {7{SEG_INV}};
  localparam logic              DP_OFF  = SEG_INV;
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_INV}};

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    case (v)
      4'h0: hex2seg = 7'h3F;
      4'h1: hex2seg = 7'h06;
      4'h2: hex2seg = 7'h5B;
      4'h3: hex2seg = 7'h4F;
      4'h4: hex2seg = 7'h66;
      4'h5: hex2seg = 7'h6D;
      4'h6: hex2seg = 7'h7D;
      4'h7: hex2seg = 7'h27;
      4'h8: hex2seg = 7'h7F;
      4'h9: hex2seg = 7'h6F;
      4'hA: hex2seg = 7'h77;
      4'hB: hex2seg = 7'h7C;
      4'hC: hex2seg = 7'h39;
      4'hD: hex2seg = 7'h5E;
      4'hE: hex2seg = 7'h79;
      default: hex2seg = 7'h71;
    endcase
  endfunction

  // Scan position
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_end, wrap;

  // Shadow / active buffers
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic                pend_q, pend_d;

  // Output registers hold pin-level values
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic              tick_q, tick_d;

  // Decode helpers
  logic [DIGITS-1:0] lz_mask;
  logic              nz_seen;
  logic [3:0]        cur_val;
  logic              cur_dp, cur_blank, cur_supp;
  logic [6:0]        seg_l;
  logic              dp_l;
  logic [DIGITS-1:0] dig_l;

  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
  end

  // A load coincident with a wrap only refills the shadow; the transfer at
  // that wrap still uses the shadow contents from before the edge.
  always_comb begin
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    pend_d      = pend_q;
    if (wrap && pend_q) begin
      act_data_d  = sh_data_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
      pend_d      = 1'b0;
    end
    if (load) begin
      sh_data_d  = data_in;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_in;
      pend_d     = 1'b1;
    end
  end

  // Zero digits above the most significant nonzero one; digit 0 excluded.
  always_comb begin
    lz_mask = '0;
    nz_seen = 1'b0;
    for (int unsigned i = 0; i + 1 < DIGITS; i++) begin
      if (!nz_seen && (act_data_q[4*(DIGITS-1-i) +: 4] == 4'h0)) begin
        lz_mask[DIGITS-1-i] = 1'b1;
      end else begin
        nz_seen = 1'b1;
      end
    end
  end

  always_comb begin
    cur_val   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    dig_l     = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_val   = act_data_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_blank = act_blank_q[k];
        cur_supp  = lz_en && lz_mask[k];
      end
      dig_l[k] = (cnt_q != '0) && (idx_q == IW'(k));
    end
    seg_l  = (cur_blank || cur_supp) ? '0 : hex2seg(cur_val);
    dp_l   = cur_dp && !cur_blank;
    seg_d  = seg_l ^ SEG_OFF;
    dp_d   = dp_l ^ DP_OFF;
    dig_d  = dig_l ^ DIG_OFF;
    tick_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      pend_q      <= 1'b0;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
      dig_q       <= DIG_OFF;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dig_q       <= dig_d;
      tick_q      <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_sel    = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4: an
// active-high instance and an active-low instance share clock and reset.
// n counts rising edges since reset release; the outputs seen after edge n
// belong to scan state n-1 (cnt=(n-1)%4, digit=((n-1)/4)%4).
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in, blank_in;
  logic        load, lz_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  logic [15:0] n_data;
  logic        n_load;
  logic [6:0]  n_seg;
  logic        n_dp;
  logic [3:0]  n_dig;
  logic        n_tick;

  int n;
  int vecs = 0;
  int errs = 0;

  seg7_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .lz_en(lz_en), .seg_out(seg_out),
    .dp_out(dp_out), .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

  seg7_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .data_in(n_data), .dp_in(4'b0000),
    .blank_in(4'b0000), .load(n_load), .lz_en(1'b0), .seg_out(n_seg),
    .dp_out(n_dp), .dig_sel(n_dig), .frame_tick(n_tick)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic logic [3:0] exp_dig(input int m);
    int s;
    s = m - 1;
    if (s % 4 == 0) return 4'b0000;
    return 4'b0001 << ((s / 4) % 4);
  endfunction

  task automatic wait_phase(input int r);
    int b;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while ((n % 16 != r) && (b < 40));
    vecs++;
    if (n % 16 != r) begin
      errs++;
      $display("FAIL wait_phase got phase %0d exp %0d", n % 16, r);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = '0; dp_in = '0; blank_in = '0;
    load = 1'b0; lz_en = 1'b0; n_data = '0; n_load = 1'b0;
    #12;
    vecs++;
    if ({seg_out, dp_out, dig_sel, frame_tick} !== 13'h0000) begin
      errs++;
      $display("FAIL reset_hi got seg=%h dp=%b dig=%b tick=%b exp 00/0/0000/0",
               seg_out, dp_out, dig_sel, frame_tick);
    end
    vecs++;
    if ({n_seg, n_dp, n_dig, n_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      errs++;
      $display("FAIL reset_lo got seg=%h dp=%b dig=%b tick=%b exp 7f/1/1111/0",
               n_seg, n_dp, n_dig, n_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] ed;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ed = exp_dig(n);
      vecs++;
      if (dig_sel !== ed) begin
        errs++;
        $display("FAIL scan_dig n=%0d got %b exp %b", n, dig_sel, ed);
      end
      if (ed != 4'b0000) begin
        vecs++;
        if (seg_out !== 7'h3F || dp_out !== 1'b0) begin
          errs++;
          $display("FAIL scan_seg n=%0d got %h/%b exp 3f/0", n, seg_out, dp_out);
        end
      end
      vecs++;
      if (frame_tick !== (n % 16 == 0)) begin
        errs++;
        $display("FAIL scan_tick n=%0d got %b exp %b", n, frame_tick, (n % 16 == 0));
      end
    end
  endtask

  task automatic test_load();
    logic [6:0] new_c [4];
    logic [6:0] es;
    int nw, k;
    new_c = '{7'h71, 7'h5B, 7'h77, 7'h06};
    wait_phase(5);
    data_in = 16'h1A2F; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nw = (n / 16 + 1) * 16;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      k = ((n - 1) / 4) % 4;
      vecs++;
      if (dig_sel !== exp_dig(n)) begin
        errs++;
        $display("FAIL load_dig n=%0d got %b exp %b", n, dig_sel, exp_dig(n));
      end
      if (exp_dig(n) != 4'b0000) begin
        es = (n - 1 >= nw) ? new_c[k] : 7'h3F;
        vecs++;
        if (seg_out !== es) begin
          errs++;
          $display("FAIL load_seg n=%0d digit %0d got %h exp %h", n, k, seg_out, es);
        end
      end
    end
    // Two loads within one frame: only the second may ever be displayed.
    wait_phase(3);
    data_in = 16'h5555; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_phase(8);
    data_in = 16'h0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nw = (n / 16 + 1) * 16;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      k = ((n - 1) / 4) % 4;
      if (exp_dig(n) != 4'b0000) begin
        es = (n - 1 >= nw) ? 7'h3F : new_c[k];
        vecs++;
        if (seg_out !== es) begin
          errs++;
          $display("FAIL reload_seg n=%0d digit %0d got %h exp %h", n, k, seg_out, es);
        end
      end
    end
  endtask

  task automatic test_lz();
    logic [6:0] old_c [4];
    logic [6:0] new_c [4];
    logic [6:0] es;
    int nw, k;
    old_c = '{7'h3F, 7'h00, 7'h00, 7'h00};
    new_c = '{7'h3F, 7'h6D, 7'h00, 7'h00};
    wait_phase(2);
    lz_en = 1'b1; data_in = 16'h0050; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nw = (n / 16 + 1) * 16;
    for (int c = 0; c < 34; c++) begin
      if (c != 0) @(negedge clk);
      k = ((n - 1) / 4) % 4;
      if (exp_dig(n) != 4'b0000) begin
        es = (n - 1 >= nw) ? new_c[k] : old_c[k];
        vecs++;
        if (seg_out !== es) begin
          errs++;
          $display("FAIL lz_seg n=%0d digit %0d got %h exp %h", n, k, seg_out, es);
        end
      end
    end
  endtask

  task automatic test_blank_dp();
    logic [6:0] old_c [4];
    logic [6:0] new_c [4];
    logic       old_d [4];
    logic       new_d [4];
    logic [6:0] es;
    logic       ed;
    int nw, k;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        old_c = '{7'h3F, 7'h6D, 7'h3F, 7'h3F}; old_d = '{1'b0, 1'b0, 1'b0, 1'b0};
        new_c = '{7'h3F, 7'h6D, 7'h00, 7'h3F}; new_d = '{1'b1, 1'b0, 1'b0, 1'b0};
      end else begin
        old_c = '{7'h3F, 7'h6D, 7'h00, 7'h00}; old_d = '{1'b1, 1'b0, 1'b0, 1'b0};
        new_c = '{7'h3F, 7'h6D, 7'h00, 7'h00}; new_d = '{1'b0, 1'b0, 1'b1, 1'b0};
      end
      wait_phase(2);
      data_in = 16'h0050; load = 1'b1;
      if (pass == 0) begin
        lz_en = 1'b0; blank_in = 4'b0100; dp_in = 4'b0101;
      end else begin
        lz_en = 1'b1; blank_in = 4'b0000; dp_in = 4'b0100;
      end
      @(negedge clk);
      load = 1'b0;
      nw = (n / 16 + 1) * 16;
      for (int c = 0; c < 34; c++) begin
        @(negedge clk);
        k = ((n - 1) / 4) % 4;
        if (exp_dig(n) != 4'b0000) begin
          es = (n - 1 >= nw) ? new_c[k] : old_c[k];
          ed = (n - 1 >= nw) ? new_d[k] : old_d[k];
          vecs++;
          if (seg_out !== es || dp_out !== ed) begin
            errs++;
            $display("FAIL blank_dp%0d n=%0d digit %0d got %h/%b exp %h/%b",
                     pass, n, k, seg_out, dp_out, es, ed);
          end
        end
      end
    end
  endtask

  task automatic test_wrap_load();
    logic [6:0] es;
    int nw1;
    wait_phase(4);
    lz_en = 1'b0; blank_in = '0; dp_in = '0;
    data_in = 16'h3333; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_phase(15);
    data_in = 16'h7777; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nw1 = n;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (exp_dig(n) != 4'b0000) begin
        es = (n - 1 >= nw1 + 16) ? 7'h27 : 7'h4F;
        vecs++;
        if (seg_out !== es || dp_out !== 1'b0) begin
          errs++;
          $display("FAIL wrap_load n=%0d got %h/%b exp %h/0", n, seg_out, dp_out, es);
        end
      end
    end
  endtask

  task automatic test_polarity();
    wait_phase(5);
    n_data = 16'h8888; n_load = 1'b1;
    @(negedge clk);
    n_load = 1'b0;
    wait_phase(1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      vecs++;
      if (n_dig !== ~exp_dig(n)) begin
        errs++;
        $display("FAIL pol_dig n=%0d got %b exp %b", n, n_dig, ~exp_dig(n));
      end
      if (exp_dig(n) != 4'b0000) begin
        vecs++;
        if (n_seg !== 7'h00 || n_dp !== 1'b1) begin
          errs++;
          $display("FAIL pol_seg n=%0d got %h/%b exp 00/1", n, n_seg, n_dp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_phase(6);
    lz_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({seg_out, dp_out, dig_sel, frame_tick} !== 13'h0000) begin
      errs++;
      $display("FAIL midrst_hi got seg=%h dp=%b dig=%b tick=%b exp 00/0/0000/0",
               seg_out, dp_out, dig_sel, frame_tick);
    end
    vecs++;
    if ({n_seg, n_dp, n_dig, n_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      errs++;
      $display("FAIL midrst_lo got seg=%h dp=%b dig=%b tick=%b exp 7f/1/1111/0",
               n_seg, n_dp, n_dig, n_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vecs++;
      if (dig_sel !== exp_dig(n)) begin
        errs++;
        $display("FAIL restart_dig n=%0d got %b exp %b", n, dig_sel, exp_dig(n));
      end
      if (exp_dig(n) != 4'b0000) begin
        vecs++;
        if (seg_out !== 7'h3F) begin
          errs++;
          $display("FAIL restart_seg n=%0d got %h exp 3f", n, seg_out);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_lz();
    test_blank_dp();
    test_wrap_load();
    test_polarity();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
